// File: rtl/config_chain_loader_pkg.sv
// Shared types and default sizing for the configuration chain loader.
package config_chain_loader_pkg;

  localparam int unsigned DefChainLen = 1024;
  localparam int unsigned DefWordW    = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StShift  = 2'd2,
    StFinish = 2'd3
  } state_e;

endpackage

// File: rtl/config_chain_loader_serializer.sv
// One-word MSB-first serializer: shift register plus in-word bit counter.
module config_chain_loader_serializer #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [WORD_W-1:0] i_data,
  output logic              o_msb,
  output logic              o_last
);

  localparam int unsigned BitCntW = $clog2(WORD_W);

  logic [WORD_W-1:0]  r_sreg;
  logic [BitCntW-1:0] r_bit_cnt;

  // A load in the same cycle as the final shift of the old word replaces it (no-bubble reload).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (i_clear) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (i_load) begin
      r_sreg    <= i_data;
      r_bit_cnt <= '0;
    end else if (i_shift) begin
      r_sreg    <= {r_sreg[WORD_W-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + BitCntW'(1);
    end
  end

  assign o_msb  = r_sreg[WORD_W-1];
  assign o_last = (r_bit_cnt == BitCntW'(WORD_W - 1));

endmodule

// File: rtl/config_chain_loader.sv
// Bitstream loader: takes words over valid/ready and shifts exactly CHAIN_LEN bits into a
// configuration scan chain, reporting busy/done/loaded status.
module config_chain_loader
  import config_chain_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = DefChainLen,
  parameter int unsigned WORD_W    = DefWordW,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              prog_in_o,
  output logic              prog_en_o,
  output logic              busy,
  output logic              done,
  output logic              cfg_loaded,
  output logic [CNT_W-1:0]  bits_left
);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_bits_left;
  logic             r_prog_in, r_prog_en, r_done, r_loaded;
  logic             w_transfer, w_shift_go, w_start_go, w_last_chain_bit;
  logic             w_word_last, w_msb;

  assign w_last_chain_bit = (r_bits_left == CNT_W'(1));
  assign w_shift_go       = (r_state == StShift) && !abort;
  assign w_start_go       = (r_state == StIdle) && start && !abort;
  assign w_transfer       = cfg_valid && cfg_ready;

  config_chain_loader_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .i_clk   (prog_clk),
    .i_rst_n (prog_rst_n),
    .i_clear (abort),
    .i_load  (w_transfer),
    .i_shift (w_shift_go),
    .i_data  (cfg_data),
    .o_msb   (w_msb),
    .o_last  (w_word_last)
  );

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:   if (start) w_state_next = StFetch;
        StFetch:  if (cfg_valid) w_state_next = StShift;
        StShift: begin
          if (w_last_chain_bit) begin
            w_state_next = StFinish;
          end else if (w_word_last) begin
            w_state_next = cfg_valid ? StShift : StFetch;
          end
        end
        StFinish: w_state_next = StIdle;
      endcase
    end
  end

  // Ready on the final bit of a word only when more chain bits remain, so no surplus is taken.
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      StIdle:   busy = 1'b0;
      StFetch:  cfg_ready = !abort;
      StShift:  cfg_ready = !abort && w_word_last && !w_last_chain_bit;
      StFinish: cfg_ready = 1'b0;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      r_prog_en   <= 1'b0;
      r_prog_in   <= 1'b0;
      r_done      <= 1'b0;
      r_loaded    <= 1'b0;
      r_bits_left <= '0;
    end else begin
      r_prog_en <= w_shift_go;
      r_prog_in <= w_shift_go & w_msb;
      r_done    <= (r_state == StFinish) && !abort;
      if (abort) begin
        r_bits_left <= '0;
        r_loaded    <= 1'b0;
      end else if (w_start_go) begin
        r_bits_left <= CNT_W'(CHAIN_LEN);
        r_loaded    <= 1'b0;
      end else begin
        if (w_shift_go) r_bits_left <= r_bits_left - CNT_W'(1);
        if (r_state == StFinish) r_loaded <= 1'b1;
      end
    end
  end

  assign prog_en_o  = r_prog_en;
  assign prog_in_o  = r_prog_in;
  assign done       = r_done;
  assign cfg_loaded = r_loaded;
  assign bits_left  = r_bits_left;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench: 20-bit and 16-bit chains modelled as shift registers fed by prog_en/prog_in.
module tb_config_chain_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 20-bit chain instance
  logic       start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       cfg_ready, prog_in_o, prog_en_o, busy, done, cfg_loaded;
  logic [4:0] bits_left;

  config_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .prog_in_o(prog_in_o), .prog_en_o(prog_en_o), .busy(busy), .done(done),
    .cfg_loaded(cfg_loaded), .bits_left(bits_left)
  );

  // 16-bit chain instance
  logic       start16 = 1'b0, abort16 = 1'b0, cfg_valid16 = 1'b0;
  logic [7:0] cfg_data16 = 8'h00;
  logic       cfg_ready16, prog_in16, prog_en16, busy16, done16, cfg_loaded16;
  logic [4:0] bits_left16;

  config_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .prog_clk(clk), .prog_rst_n(rst_n), .start(start16), .abort(abort16),
    .cfg_data(cfg_data16), .cfg_valid(cfg_valid16), .cfg_ready(cfg_ready16),
    .prog_in_o(prog_in16), .prog_en_o(prog_en16), .busy(busy16), .done(done16),
    .cfg_loaded(cfg_loaded16), .bits_left(bits_left16)
  );

  int checks = 0;
  int errors = 0;

  // Chain models, sampled mid-cycle
  logic        mon_clr = 1'b0;
  logic [19:0] chain;
  int          en_cnt, run, max_run, gap_cnt, done_cnt, acc_cnt, ready_late;
  logic [15:0] chain16;
  int          en16, done16_cnt, acc16, done_align;
  logic        prev_en16;

  always @(negedge clk) begin
    if (mon_clr) begin
      chain <= '0; en_cnt <= 0; run <= 0; max_run <= 0; gap_cnt <= 0;
      done_cnt <= 0; acc_cnt <= 0; ready_late <= 0;
    end else begin
      if (prog_en_o) begin
        chain  <= {chain[18:0], prog_in_o};
        en_cnt <= en_cnt + 1;
        run    <= run + 1;
        if (run + 1 > max_run) max_run <= run + 1;
      end else begin
        run <= 0;
        if (en_cnt > 0 && en_cnt < 20) gap_cnt <= gap_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (cfg_valid && cfg_ready) acc_cnt <= acc_cnt + 1;
      if (en_cnt == 20 && cfg_ready) ready_late <= ready_late + 1;
    end
  end

  initial begin
    chain16 = '0; en16 = 0; done16_cnt = 0; acc16 = 0; done_align = 0; prev_en16 = 1'b0;
  end

  always @(negedge clk) begin
    prev_en16 <= prog_en16;
    if (prog_en16) begin
      chain16 <= {chain16[14:0], prog_in16};
      en16    <= en16 + 1;
    end
    if (done16) done16_cnt <= done16_cnt + 1;
    if (done16 && prev_en16 && !prog_en16) done_align <= done_align + 1;
    if (cfg_valid16 && cfg_ready16) acc16 <= acc16 + 1;
  end

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    bit got = 1'b0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = cfg_ready;
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_word_%h: cfg_ready=0 for 100 cycles, required 1", w);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done;
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_done: done=0 for 100 cycles, required 1");
    end
  endtask

  task automatic full_load(input int gap);
    pulse_start();
    send_word(8'hA5);
    if (gap > 0) begin
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (cfg_ready) break;
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      repeat (gap - 1) begin @(posedge clk); #1; end
    end
    send_word(8'h3C);
    send_word(8'hF0);
    wait_done();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({prog_en_o, prog_in_o, busy, done, cfg_loaded, cfg_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: en,in,busy,done,loaded,ready=%b required 000000",
               {prog_en_o, prog_in_o, busy, done, cfg_loaded, cfg_ready});
    end
    checks++;
    if (bits_left !== 5'd0) begin
      errors++;
      $display("FAIL reset_bits_left: got %0d required 0", bits_left);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b ready=%b required 0 0", busy, cfg_ready);
    end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bits_left !== 5'd20 || cfg_ready !== 1'b1 || prog_en_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fetch: busy=%b bits_left=%0d ready=%b en=%b required 1 20 1 0",
               busy, bits_left, cfg_ready, prog_en_o);
    end
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hF0);
    wait_done();
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (chain !== 20'hA53CF) begin
      errors++;
      $display("FAIL b2b_chain: got %h required a53cf", chain);
    end
    checks++;
    if (en_cnt != 20 || max_run != 20) begin
      errors++;
      $display("FAIL b2b_en: count=%0d run=%0d required 20 20", en_cnt, max_run);
    end
    checks++;
    if (done_cnt != 1 || cfg_loaded !== 1'b1 || busy !== 1'b0 || bits_left !== 5'd0) begin
      errors++;
      $display("FAIL b2b_status: done_cnt=%0d loaded=%b busy=%b bits_left=%0d required 1 1 0 0",
               done_cnt, cfg_loaded, busy, bits_left);
    end
  endtask

  task automatic test_gap();
    clr_mon();
    full_load(5);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (chain !== 20'hA53CF) begin
      errors++;
      $display("FAIL gap_chain: got %h required a53cf", chain);
    end
    checks++;
    if (en_cnt != 20 || gap_cnt != 5 || max_run != 12) begin
      errors++;
      $display("FAIL gap_en: count=%0d gap=%0d run=%0d required 20 5 12",
               en_cnt, gap_cnt, max_run);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL gap_done: got %0d pulses required 1", done_cnt);
    end
  endtask

  task automatic test_abort();
    bit hit = 1'b0;
    clr_mon();
    pulse_start();
    send_word(8'hA5);
    cfg_data  = 8'h3C;
    cfg_valid = 1'b1;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = (en_cnt == 9);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_reach9: shifted %0d bits, required 9", en_cnt);
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort     = 1'b0;
    cfg_valid = 1'b0;
    checks++;
    if ({busy, prog_en_o, cfg_ready, cfg_loaded} !== 4'b0 || bits_left !== 5'd0) begin
      errors++;
      $display("FAIL abort_state: busy,en,ready,loaded=%b bits_left=%0d required 0000 0",
               {busy, prog_en_o, cfg_ready, cfg_loaded}, bits_left);
    end
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone: done_cnt=%0d busy=%b required 0 0", done_cnt, busy);
    end
    clr_mon();
    full_load(0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (chain !== 20'hA53CF || en_cnt != 20) begin
      errors++;
      $display("FAIL abort_reload: chain=%h count=%0d required a53cf 20", chain, en_cnt);
    end
  endtask

  task automatic test_start_ignored();
    clr_mon();
    pulse_start();
    send_word(8'hA5);
    pulse_start();
    send_word(8'h3C);
    send_word(8'hF0);
    wait_done();
    cfg_data  = 8'h11;
    cfg_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    cfg_valid = 1'b0;
    checks++;
    if (acc_cnt != 3 || ready_late != 0) begin
      errors++;
      $display("FAIL ignore_words: accepted=%0d late_ready=%0d required 3 0", acc_cnt, ready_late);
    end
    checks++;
    if (chain !== 20'hA53CF || en_cnt != 20 || done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_chain: chain=%h count=%0d done=%0d required a53cf 20 1",
               chain, en_cnt, done_cnt);
    end
    checks++;
    if (busy !== 1'b0 || bits_left !== 5'd0 || cfg_loaded !== 1'b1) begin
      errors++;
      $display("FAIL ignore_status: busy=%b bits_left=%0d loaded=%b required 0 0 1",
               busy, bits_left, cfg_loaded);
    end
  endtask

  task automatic test_reset_mid();
    clr_mon();
    pulse_start();
    send_word(8'hA5);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({prog_en_o, prog_in_o, busy, done, cfg_loaded, cfg_ready} !== 6'b0 ||
        bits_left !== 5'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: en,in,busy,done,loaded,ready=%b bits_left=%0d required 0",
               {prog_en_o, prog_in_o, busy, done, cfg_loaded, cfg_ready}, bits_left);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || prog_en_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: busy=%b en=%b required 0 0", busy, prog_en_o);
    end
    clr_mon();
    full_load(0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (chain !== 20'hA53CF || cfg_loaded !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reload: chain=%h loaded=%b required a53cf 1", chain, cfg_loaded);
    end
  endtask

  task automatic send_word16(input logic [7:0] w);
    bit got = 1'b0;
    cfg_data16  = w;
    cfg_valid16 = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = cfg_ready16;
      @(posedge clk); #1;
    end
    cfg_valid16 = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send16_%h: cfg_ready=0 for 100 cycles, required 1", w);
    end
  endtask

  task automatic test_chain16();
    bit seen = 1'b0;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    send_word16(8'h5A);
    send_word16(8'hC3);
    cfg_data16  = 8'h77;
    cfg_valid16 = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done16;
      @(posedge clk); #1;
    end
    repeat (4) begin @(posedge clk); #1; end
    cfg_valid16 = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL c16_done_seen: done=0 for 100 cycles, required 1");
    end
    checks++;
    if (chain16 !== 16'h5AC3 || en16 != 16) begin
      errors++;
      $display("FAIL c16_chain: chain=%h count=%0d required 5ac3 16", chain16, en16);
    end
    checks++;
    if (done16_cnt != 1 || done_align != 1 || acc16 != 2) begin
      errors++;
      $display("FAIL c16_done: pulses=%0d aligned=%0d accepted=%0d required 1 1 2",
               done16_cnt, done_align, acc16);
    end
    checks++;
    if (cfg_loaded16 !== 1'b1 || busy16 !== 1'b0 || bits_left16 !== 5'd0) begin
      errors++;
      $display("FAIL c16_status: loaded=%b busy=%b bits_left=%0d required 1 0 0",
               cfg_loaded16, busy16, bits_left16);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_chain16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
